// File: rtl/mod_counter_n_pkg.sv
// Shared constants for the clock-datapath digit counters.
// Direction encodings, clock-field moduli and a width helper.
package counter_pkg;

    localparam logic CNT_DIR_UP   = 1'b1;
    localparam logic CNT_DIR_DOWN = 1'b0;

    localparam int MOD_SEC_LO = 10;
    localparam int MOD_SEC_HI = 6;
    localparam int MOD_HR     = 24;

    // Bits needed to hold 0..n-1.
    function automatic int clog2(input int n);
        int r;
        int v;
        r = 0;
        v = n - 1;
        while (v > 0) begin
            r++;
            v = v >> 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/mod_counter_n_if.sv
// Control/status bundle between a digit counter and its driver.
// MOD_COUNTER_N_SAT_EN adds the sat_mode control line.
interface mod_counter_n_if #(
    parameter int WIDTH = 4
);
    logic             clr;
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic             cnt_en;
    logic             cnt_up;
`ifdef MOD_COUNTER_N_SAT_EN
    logic             sat_mode;
`endif
    logic [WIDTH-1:0] cnt;
    logic             carryout;
    logic             borrowout;
    logic             load_err;

`ifdef MOD_COUNTER_N_SAT_EN
    modport master (
        output clr, load, load_val, cnt_en, cnt_up, sat_mode,
        input  cnt, carryout, borrowout, load_err
    );
    modport slave (
        input  clr, load, load_val, cnt_en, cnt_up, sat_mode,
        output cnt, carryout, borrowout, load_err
    );
`else
    modport master (
        output clr, load, load_val, cnt_en, cnt_up,
        input  cnt, carryout, borrowout, load_err
    );
    modport slave (
        input  clr, load, load_val, cnt_en, cnt_up,
        output cnt, carryout, borrowout, load_err
    );
`endif

endinterface

// File: rtl/dreg.sv
// Single-bit D flip-flop cell, no reset.
// Reset is applied by the caller through its next-state logic.
module dreg (
    input  logic clk,
    input  logic d,
    output logic q
);

    always_ff @(posedge clk) begin
        q <= d;
    end

endmodule

// File: rtl/mod_counter_n_next.sv
// Next-state logic for mod_counter_n: priority rst > clr > load > cnt_en.
// Arithmetic at WIDTH+1 bits so MODULUS == 2**WIDTH cannot overflow.
module mod_counter_n_next #(
    parameter int WIDTH     = 4,
    parameter int MODULUS   = 10,
    parameter int RESET_VAL = 0
) (
    input  logic [WIDTH-1:0] cnt,
    input  logic             rst,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             cnt_en,
    input  logic             cnt_up,
    input  logic             sat,
    output logic [WIDTH-1:0] nxt,
    output logic             err
);

    localparam int W1 = WIDTH + 1;
    localparam logic [WIDTH:0]   MOD_W = W1'(MODULUS);
    localparam logic [WIDTH:0]   ONE_W = W1'(1);
    localparam logic [WIDTH-1:0] TOP   = WIDTH'(MODULUS - 1);
    localparam logic [WIDTH-1:0] RST_V = WIDTH'(RESET_VAL);

    logic [WIDTH:0] cnt_w;
    logic [WIDTH:0] ld_w;
    logic [WIDTH:0] inc_w;
    logic [WIDTH:0] dec_w;

    assign cnt_w = {1'b0, cnt};
    assign ld_w  = {1'b0, load_val};
    assign inc_w = cnt_w + ONE_W;
    assign dec_w = cnt_w - ONE_W;

    always_comb begin
        nxt = cnt;
        err = 1'b0;
        if (rst) begin
            nxt = RST_V;
        end else if (clr) begin
            nxt = '0;
        end else if (load) begin
            if (ld_w < MOD_W) begin
                nxt = load_val;
            end else begin
                nxt = TOP;
                err = 1'b1;
            end
        end else if (cnt_en) begin
            if (cnt_up) begin
                // Also catches an out-of-range count, which restarts at 0.
                if (inc_w >= MOD_W) nxt = sat ? TOP : '0;
                else                nxt = inc_w[WIDTH-1:0];
            end else begin
                if (cnt_w == '0)         nxt = sat ? '0 : TOP;
                else if (cnt_w >= MOD_W) nxt = TOP;
                else                     nxt = dec_w[WIDTH-1:0];
            end
        end
    end

endmodule

// File: rtl/mod_counter_n.sv
// Modulo-N up/down digit counter with ripple carry/borrow for chaining.
// Define MOD_COUNTER_N_SAT_EN to add saturating mode (bus.sat_mode).
module mod_counter_n
    import counter_pkg::*;
#(
    parameter int WIDTH     = 4,
    parameter int MODULUS   = 10,
    parameter int RESET_VAL = 0
) (
    input logic            clk,
    input logic            rst_n,
    mod_counter_n_if.slave bus
);

    localparam logic [WIDTH-1:0] TOP = WIDTH'(MODULUS - 1);

    if (WIDTH < 1 || WIDTH > 16 || MODULUS < 2 ||
        MODULUS > (1 << WIDTH) ||
        RESET_VAL < 0 || RESET_VAL >= MODULUS) begin : g_bad_cfg
        $fatal(1, "mod_counter_n: illegal WIDTH/MODULUS/RESET_VAL");
    end

    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_d;
    logic             err_q;
    logic             err_d;
    logic             sat;

`ifdef MOD_COUNTER_N_SAT_EN
    assign sat = bus.sat_mode;
`else
    assign sat = 1'b0;
`endif

    mod_counter_n_next #(
        .WIDTH     (WIDTH),
        .MODULUS   (MODULUS),
        .RESET_VAL (RESET_VAL)
    ) u_next (
        .cnt      (cnt_q),
        .rst      (rst_n),
        .clr      (bus.clr),
        .load     (bus.load),
        .load_val (bus.load_val),
        .cnt_en   (bus.cnt_en),
        .cnt_up   (bus.cnt_up),
        .sat      (sat),
        .nxt      (cnt_d),
        .err      (err_d)
    );

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        dreg u_bit (
            .clk (clk),
            .d   (cnt_d[i]),
            .q   (cnt_q[i])
        );
    end

    dreg u_err (
        .clk (clk),
        .d   (err_d),
        .q   (err_q)
    );

    // Carry/borrow ignore clr/load so the next digit still sees the wrap.
    assign bus.carryout  = bus.cnt_en & (bus.cnt_up == CNT_DIR_UP) &
                           ~sat & (cnt_q == TOP);
    assign bus.borrowout = bus.cnt_en & (bus.cnt_up == CNT_DIR_DOWN) &
                           ~sat & (cnt_q == '0);
    assign bus.cnt       = cnt_q;
    assign bus.load_err  = err_q;

endmodule

// File: tb/tb_mod_counter_n.sv
// Bench for mod_counter_n: mod-10, mod-16 and a chained mod-10/mod-6 pair
// against an arithmetic reference model, directed then random stimulus.
module tb_mod_counter_n;
    import counter_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;
    int   n_chk  = 0;
    int   n_pass = 0;
    bit   s10    = 1'b0;

    mod_counter_n_if #(.WIDTH(4)) i10 ();
    mod_counter_n_if #(.WIDTH(4)) i16 ();
    mod_counter_n_if #(.WIDTH(4)) ilo ();
    mod_counter_n_if #(.WIDTH(3)) ihi ();

    mod_counter_n #(.WIDTH(4), .MODULUS(MOD_SEC_LO), .RESET_VAL(0))
        u10 (.clk(clk), .rst_n(rst_n), .bus(i10.slave));
    mod_counter_n #(.WIDTH(4), .MODULUS(16), .RESET_VAL(5))
        u16 (.clk(clk), .rst_n(rst_n), .bus(i16.slave));
    mod_counter_n #(.WIDTH(4), .MODULUS(MOD_SEC_LO), .RESET_VAL(0))
        ulo (.clk(clk), .rst_n(rst_n), .bus(ilo.slave));
    mod_counter_n #(.WIDTH(3), .MODULUS(MOD_SEC_HI), .RESET_VAL(0))
        uhi (.clk(clk), .rst_n(rst_n), .bus(ihi.slave));

    assign ihi.cnt_en = ilo.carryout;

`ifdef MOD_COUNTER_N_SAT_EN
    assign i10.sat_mode = s10;
    assign i16.sat_mode = 1'b0;
    assign ilo.sat_mode = 1'b0;
    assign ihi.sat_mode = 1'b0;
`endif

    int m10, m16, mlo, mhi;
    bit e10, e16, elo, ehi;

    function automatic int nxt(int m, int md, int rv, bit r, bit c,
                               bit l, int lv, bit en, bit up, bit sat);
        if (r) return rv;
        if (c) return 0;
        if (l) return (lv < md) ? lv : md - 1;
        if (!en) return m;
        if (sat) return up ? ((m + 1 < md) ? m + 1 : md - 1)
                           : ((m > 0) ? m - 1 : 0);
        return up ? (m + 1) % md : (m + md - 1) % md;
    endfunction

    function automatic bit nerr(bit r, bit c, bit l, int lv, int md);
        return !r && !c && l && (lv >= md);
    endfunction

    function automatic bit co_x(int m, int md, bit en, bit up, bit sat);
        return en && up && !sat && (m == md - 1);
    endfunction

    function automatic bit bo_x(int m, bit en, bit up, bit sat);
        return en && !up && !sat && (m == 0);
    endfunction

    task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    endtask

    task automatic step();
        int n10, n16, nlo, nhi;
        bit f10, f16, flo, fhi, enhi;
        @(negedge clk);
        chk("cnt10", 32'(i10.cnt), m10);
        chk("co10", 32'(i10.carryout),
            32'(co_x(m10, 10, i10.cnt_en, i10.cnt_up, s10)));
        chk("bo10", 32'(i10.borrowout),
            32'(bo_x(m10, i10.cnt_en, i10.cnt_up, s10)));
        chk("lerr10", 32'(i10.load_err), 32'(e10));
        chk("cnt16", 32'(i16.cnt), m16);
        chk("co16", 32'(i16.carryout),
            32'(co_x(m16, 16, i16.cnt_en, i16.cnt_up, 1'b0)));
        chk("lerr16", 32'(i16.load_err), 32'(e16));
        chk("cntlo", 32'(ilo.cnt), mlo);
        chk("lerrlo", 32'(ilo.load_err), 32'(elo));
        enhi = co_x(mlo, 10, ilo.cnt_en, ilo.cnt_up, 1'b0);
        chk("colo", 32'(ilo.carryout), 32'(enhi));
        chk("cnthi", 32'(ihi.cnt), mhi);
        chk("cohi", 32'(ihi.carryout),
            32'(co_x(mhi, 6, enhi, ihi.cnt_up, 1'b0)));
        n10 = nxt(m10, 10, 0, rst_n, i10.clr, i10.load, int'(i10.load_val),
                  i10.cnt_en, i10.cnt_up, s10);
        f10 = nerr(rst_n, i10.clr, i10.load, int'(i10.load_val), 10);
        n16 = nxt(m16, 16, 5, rst_n, i16.clr, i16.load, int'(i16.load_val),
                  i16.cnt_en, i16.cnt_up, 1'b0);
        f16 = nerr(rst_n, i16.clr, i16.load, int'(i16.load_val), 16);
        nlo = nxt(mlo, 10, 0, rst_n, ilo.clr, ilo.load, int'(ilo.load_val),
                  ilo.cnt_en, ilo.cnt_up, 1'b0);
        flo = nerr(rst_n, ilo.clr, ilo.load, int'(ilo.load_val), 10);
        nhi = nxt(mhi, 6, 0, rst_n, ihi.clr, ihi.load, int'(ihi.load_val),
                  enhi, ihi.cnt_up, 1'b0);
        fhi = nerr(rst_n, ihi.clr, ihi.load, int'(ihi.load_val), 6);
        @(posedge clk);
        m10 = n10; e10 = f10;
        m16 = n16; e16 = f16;
        mlo = nlo; elo = flo;
        mhi = nhi; ehi = fhi;
        #1;
    endtask

    task automatic drv10(bit c, bit l, int lv, bit en, bit up);
        i10.clr      = c;
        i10.load     = l;
        i10.load_val = 4'(lv);
        i10.cnt_en   = en;
        i10.cnt_up   = up;
    endtask

    initial begin
        rst_n = 1'b1;
        drv10(0, 0, 0, 0, 1);
        i16.clr = 0; i16.load = 0; i16.load_val = '0;
        i16.cnt_en = 0; i16.cnt_up = 1;
        ilo.clr = 0; ilo.load = 0; ilo.load_val = '0;
        ilo.cnt_en = 0; ilo.cnt_up = 1;
        ihi.clr = 0; ihi.load = 0; ihi.load_val = '0; ihi.cnt_up = 1;
        repeat (2) @(posedge clk);
        #1;
        m10 = 0; m16 = 5; mlo = 0; mhi = 0;
        e10 = 0; e16 = 0; elo = 0; ehi = 0;
        rst_n = 1'b0;

        // Up-count from reset through a wrap.
        drv10(0, 0, 0, 1, CNT_DIR_UP);
        repeat (12) step();

        // Down-count from reset.
        rst_n = 1'b1; step(); rst_n = 1'b0;
        drv10(0, 0, 0, 1, CNT_DIR_DOWN);
        repeat (12) step();

        // In-range then out-of-range load; load_err is a one-cycle pulse.
        drv10(0, 1, 7, 0, 1);  step();
        drv10(0, 1, 12, 0, 1); step();
        drv10(0, 0, 0, 0, 1);  repeat (2) step();

        // Terminal count with clr, then reset with enable high.
        drv10(0, 1, 9, 0, 1); step();
        drv10(1, 0, 0, 1, 1); step();
        drv10(0, 0, 0, 1, 1); rst_n = 1'b1; step();
        rst_n = 1'b0;
        drv10(0, 0, 0, 0, 1); step();

        // Full-range modulus and the chained seconds pair.
        rst_n = 1'b1; step(); rst_n = 1'b0;
        i16.cnt_en = 1; ilo.cnt_en = 1;
        repeat (64) step();
        i16.cnt_en = 0; ilo.cnt_en = 0;

`ifdef MOD_COUNTER_N_SAT_EN
        drv10(0, 1, 8, 0, 1); step();
        s10 = 1'b1;
        drv10(0, 0, 0, 1, 1); repeat (4) step();
        drv10(0, 0, 0, 1, 0); repeat (11) step();
        s10 = 1'b0;
        drv10(0, 1, 8, 0, 1); step();
        drv10(0, 0, 0, 1, 1); repeat (3) step();
`endif

        for (int k = 0; k < 500; k++) begin
            rst_n = ($urandom_range(0, 40) == 0);
            drv10($urandom_range(0, 15) == 0, $urandom_range(0, 7) == 0,
                  int'($urandom_range(0, 15)), $urandom_range(0, 3) != 0,
                  $urandom_range(0, 1) == 1);
            i16.clr      = ($urandom_range(0, 15) == 0);
            i16.load     = ($urandom_range(0, 7) == 0);
            i16.load_val = 4'($urandom_range(0, 15));
            i16.cnt_en   = ($urandom_range(0, 3) != 0);
            i16.cnt_up   = ($urandom_range(0, 1) == 1);
            ilo.load     = ($urandom_range(0, 31) == 0);
            ilo.load_val = 4'($urandom_range(0, 15));
            ilo.cnt_en   = ($urandom_range(0, 3) != 0);
`ifdef MOD_COUNTER_N_SAT_EN
            s10 = ($urandom_range(0, 3) == 0);
`endif
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
